// File: rtl/pc_predict_if.sv
// Fetch next-PC bundle: stall/trap controls and EX resolution in, fetch PC and prediction out.
// Latency: pure wiring, no state.
// Backpressure: stall is the only hold; trap and mispredict redirect regardless of it.
//
// Ports (slave = the predictor):
//   stall, trap_en, trap_vec           : hazard hold and trap redirect request/target
//   ex_valid, ex_branch, ex_taken      : EX-stage resolution of the instruction at ex_pc
//   ex_pc, ex_target                   : EX instruction address and resolved taken target
//   ex_pred_taken, ex_pred_target      : what fetch predicted for that instruction
//   pc, pred_taken, pred_target, flush : fetch PC, current prediction, pipeline kill
interface pc_predict_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 stall;
    logic                 trap_en;
    logic [CPU_WIDTH-1:0] trap_vec;
    logic                 ex_valid;
    logic                 ex_branch;
    logic                 ex_taken;
    logic [CPU_WIDTH-1:0] ex_pc;
    logic [CPU_WIDTH-1:0] ex_target;
    logic                 ex_pred_taken;
    logic [CPU_WIDTH-1:0] ex_pred_target;
    logic [CPU_WIDTH-1:0] pc;
    logic                 pred_taken;
    logic [CPU_WIDTH-1:0] pred_target;
    logic                 flush;

    modport master (
        output stall, trap_en, trap_vec,
        output ex_valid, ex_branch, ex_taken, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        input  pc, pred_taken, pred_target, flush
    );

    modport slave (
        input  stall, trap_en, trap_vec,
        input  ex_valid, ex_branch, ex_taken, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        output pc, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB of 2-bit saturating counters; flushes on mispredict/trap.
// Latency: prediction steers the next PC in the cycle pc is shown; EX redirect lands one edge after EX.
// Backpressure: stall holds pc; trap and mispredict override stall. BTB training ignores stall/trap.
//
// Ports: clk, rst_n (async active-low); bus (pc_predict_if.slave) carries all control,
// EX resolution inputs and the pc / pred_taken / pred_target / flush outputs.
module pc_predict_unit #(
    parameter int                   CPU_WIDTH = 32,
    parameter int                   BTB_DEPTH = 16,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_predict_if.slave  bus
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = CPU_WIDTH - IDX_W - 2;

    logic [CPU_WIDTH-1:0] pc_q;
    logic [CPU_WIDTH-1:0] pc_nxt;
    logic [CPU_WIDTH-1:0] pc_plus4;
    logic [CPU_WIDTH-1:0] ex_plus4;

    logic [BTB_DEPTH-1:0] btb_vld;
    logic [1:0]           btb_ctr [BTB_DEPTH];
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [CPU_WIDTH-1:0] btb_tgt [BTB_DEPTH];

    logic [IDX_W-1:0]     f_idx;
    logic [TAG_W-1:0]     f_tag;
    logic                 f_hit;
    logic [IDX_W-1:0]     e_idx;
    logic [TAG_W-1:0]     e_tag;
    logic                 e_hit;
    logic                 mispred;
    logic [CPU_WIDTH-1:0] redirect;

    assign pc_plus4 = pc_q + CPU_WIDTH'(4);
    assign ex_plus4 = bus.ex_pc + CPU_WIDTH'(4);

    // Fetch-side lookup reads the array before any same-cycle update lands.
    assign f_idx = pc_q[IDX_W+1:2];
    assign f_tag = pc_q[CPU_WIDTH-1:IDX_W+2];
    assign f_hit = btb_vld[f_idx] && (btb_tag[f_idx] == f_tag);

    assign e_idx = bus.ex_pc[IDX_W+1:2];
    assign e_tag = bus.ex_pc[CPU_WIDTH-1:IDX_W+2];
    assign e_hit = btb_vld[e_idx] && (btb_tag[e_idx] == e_tag);

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = f_hit && btb_ctr[f_idx][1];
    assign bus.pred_target = f_hit ? btb_tgt[f_idx] : pc_plus4;

    // A taken/taken pair still mispredicts when the predicted target was stale.
    assign mispred = bus.ex_valid && bus.ex_branch &&
                     ((bus.ex_taken != bus.ex_pred_taken) ||
                      (bus.ex_taken && bus.ex_pred_taken && (bus.ex_target != bus.ex_pred_target)));
    assign redirect  = bus.ex_taken ? bus.ex_target : ex_plus4;
    assign bus.flush = bus.trap_en || mispred;

    always_comb begin
        pc_nxt = pc_plus4;
        if (bus.trap_en)         pc_nxt = bus.trap_vec;
        else if (mispred)        pc_nxt = redirect;
        else if (bus.stall)      pc_nxt = pc_q;
        else if (bus.pred_taken) pc_nxt = bus.pred_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_nxt;
    end

    // Valid bits and counters carry the reset state; tag/target are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_vld <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) btb_ctr[i] <= 2'b00;
        end else if (bus.ex_valid && bus.ex_branch) begin
            if (e_hit) begin
                if (bus.ex_taken)
                    btb_ctr[e_idx] <= (btb_ctr[e_idx] == 2'b11) ? 2'b11 : btb_ctr[e_idx] + 2'd1;
                else
                    btb_ctr[e_idx] <= (btb_ctr[e_idx] == 2'b00) ? 2'b00 : btb_ctr[e_idx] - 2'd1;
            end else if (bus.ex_taken) begin
                btb_vld[e_idx] <= 1'b1;
                btb_ctr[e_idx] <= 2'b10;
            end
        end else if (bus.ex_valid && e_hit) begin
            // A non-branch hit means the entry aliases ordinary code: drop it.
            btb_vld[e_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.ex_valid && bus.ex_branch && bus.ex_taken) begin
            btb_tgt[e_idx] <= bus.ex_target;
            if (!e_hit) btb_tag[e_idx] <= e_tag;
        end
    end
endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_predict_if #(.CPU_WIDTH(32)) bus ();

    pc_predict_unit #(
        .CPU_WIDTH(32),
        .BTB_DEPTH(16),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        fl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle against the DUT outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, "pc",          bus.pc,                  e.pc);
                chk(e.name, "pred_taken",  {31'd0, bus.pred_taken}, {31'd0, e.pt});
                chk(e.name, "pred_target", bus.pred_target,         e.ptgt);
                chk(e.name, "flush",       {31'd0, bus.flush},      {31'd0, e.fl});
            end
        end
    end

    // Drive one cycle of inputs, queue the outputs expected during that cycle, advance.
    task automatic step(input string nm,
                        input logic st, input logic tr, input logic [31:0] tv,
                        input logic ev, input logic eb, input logic et,
                        input logic [31:0] epc, input logic [31:0] etgt,
                        input logic ept, input logic [31:0] eptgt,
                        input logic [31:0] xpc, input logic xpt, input logic [31:0] xptgt,
                        input logic xfl);
        exp_t e;
        bus.stall          = st;
        bus.trap_en        = tr;
        bus.trap_vec       = tv;
        bus.ex_valid       = ev;
        bus.ex_branch      = eb;
        bus.ex_taken       = et;
        bus.ex_pc          = epc;
        bus.ex_target      = etgt;
        bus.ex_pred_taken  = ept;
        bus.ex_pred_target = eptgt;
        e.name = nm; e.pc = xpc; e.pt = xpt; e.ptgt = xptgt; e.fl = xfl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [31:0] xpc, input logic xpt, input logic [31:0] xptgt);
        step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, xpc, xpt, xptgt, 0);
    endtask

    task automatic trap_to(input string nm, input logic [31:0] tv, input logic [31:0] xpc,
                           input logic xpt, input logic [31:0] xptgt);
        step(nm, 0, 1, tv, 0, 0, 0, 0, 0, 0, 0, xpc, xpt, xptgt, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 0; bus.trap_en = 0; bus.trap_vec = 0;
        bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_taken = 0;
        bus.ex_pc = 0; bus.ex_target = 0; bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
        @(posedge clk); #1;
        idle("in_reset", 32'h0, 0, 32'h4);
        rst_n = 1'b1;

        // Sequential fetch after reset release
        idle("seq0", 32'h00, 0, 32'h04);
        idle("seq4", 32'h04, 0, 32'h08);
        idle("seq8", 32'h08, 0, 32'h0C);
        idle("seqC", 32'h0C, 0, 32'h10);
        idle("seq10_cold", 32'h10, 0, 32'h14);

        // Cold taken branch at 0x10 -> 0x40
        step("cold_taken", 0, 0, 0, 1, 1, 1, 32'h10, 32'h40, 0, 0, 32'h14, 0, 32'h18, 1);
        idle("after_cold", 32'h40, 0, 32'h44);
        trap_to("trap_a", 32'h10, 32'h44, 0, 32'h48);
        idle("pred_hit", 32'h10, 1, 32'h40);
        idle("follow_pred", 32'h40, 0, 32'h44);

        // Saturate counter with correctly-predicted taken resolutions while stalled
        step("sat1", 1, 0, 0, 1, 1, 1, 32'h10, 32'h40, 1, 32'h40, 32'h44, 0, 32'h48, 0);
        step("sat2", 1, 0, 0, 1, 1, 1, 32'h10, 32'h40, 1, 32'h40, 32'h44, 0, 32'h48, 0);
        step("sat3", 1, 0, 0, 1, 1, 1, 32'h10, 32'h40, 1, 32'h40, 32'h44, 0, 32'h48, 0);
        // Not-taken while predicted taken: mispredict overrides stall, ctr 11->10
        step("nt_mis", 1, 0, 0, 1, 1, 0, 32'h10, 32'h40, 1, 32'h40, 32'h44, 0, 32'h48, 1);
        idle("redir_14", 32'h14, 0, 32'h18);
        trap_to("trap_b", 32'h10, 32'h18, 0, 32'h1C);
        // ctr 10 still predicts taken; same-cycle decrement not yet visible
        step("ctr10_rw", 0, 0, 0, 1, 1, 0, 32'h10, 32'h40, 0, 0, 32'h10, 1, 32'h40, 0);
        trap_to("trap_c", 32'h10, 32'h40, 0, 32'h44);
        idle("ctr01", 32'h10, 0, 32'h40);

        // Wrong target: predicted 0x40, resolved 0x80
        step("wrong_tgt", 0, 0, 0, 1, 1, 1, 32'h10, 32'h80, 1, 32'h40, 32'h14, 0, 32'h18, 1);
        idle("redir_80", 32'h80, 0, 32'h84);
        trap_to("trap_d", 32'h10, 32'h84, 0, 32'h88);
        idle("new_tgt", 32'h10, 1, 32'h80);

        // Priority: trap beats mispredict beats stall
        step("prio", 1, 1, 32'h100, 1, 1, 0, 32'h200, 0, 1, 32'h300, 32'h80, 0, 32'h84, 1);
        idle("at_trap", 32'h100, 0, 32'h104);

        // Alias cleanup
        step("alias_miss", 0, 0, 0, 1, 0, 0, 32'h50, 0, 0, 0, 32'h104, 0, 32'h108, 0);
        trap_to("trap_e", 32'h10, 32'h108, 0, 32'h10C);
        step("alias_hit", 0, 0, 0, 1, 0, 0, 32'h10, 0, 0, 0, 32'h10, 1, 32'h80, 0);
        trap_to("trap_f", 32'h10, 32'h80, 0, 32'h84);
        idle("alias_gone", 32'h10, 0, 32'h14);

        // Reallocate, then reset mid-stream
        step("realloc", 0, 0, 0, 1, 1, 1, 32'h10, 32'h40, 0, 0, 32'h14, 0, 32'h18, 1);
        trap_to("trap_g", 32'h10, 32'h40, 0, 32'h44);
        idle("realloc_hit", 32'h10, 1, 32'h40);
        rst_n = 1'b0;
        idle("mid_reset", 32'h0, 0, 32'h4);
        rst_n = 1'b1;
        idle("post_rst0", 32'h0, 0, 32'h4);
        trap_to("trap_h", 32'h10, 32'h4, 0, 32'h8);
        // Entry cleared by reset; also trap to the top of the address space
        trap_to("cleared", 32'hFFFF_FFFC, 32'h10, 0, 32'h14);
        idle("wrap_top", 32'hFFFF_FFFC, 0, 32'h0);
        idle("wrap_zero", 32'h0, 0, 32'h4);

        @(posedge clk); #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Fetch-stage next-PC generator for the five-stage pipeline; the parametrised successor of the simple branch&zero PC select.
- Holds the fetch PC register and predicts taken branches/jumps with a direct-mapped BTB of 2-bit saturating counters.
- Accepts resolution from EX, raises flush on misprediction or trap, and supports stall and trap redirect.

Parameters:
- CPU_WIDTH, 32, datapath/PC width in bits.
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2; IDX_W = log2(BTB_DEPTH).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold fetch PC; from hazard unit.
- trap_en  in  1  trap/exception redirect request.
- trap_vec  in  CPU_WIDTH  trap target address.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_branch  in  1  EX instruction is a branch or jump.
- ex_taken  in  1  resolved direction; branch&zero, or 1 for jumps.
- ex_pc  in  CPU_WIDTH  PC of the EX instruction.
- ex_target  in  CPU_WIDTH  resolved taken target.
- ex_pred_taken  in  1  prediction made for this instruction at fetch, piped forward.
- ex_pred_target  in  CPU_WIDTH  predicted target, piped forward.
- pc  out  CPU_WIDTH  current fetch PC (registered).
- pred_taken  out  1  BTB predicts taken for pc (combinational).
- pred_target  out  CPU_WIDTH  predicted target for pc (combinational).
- flush  out  1  kill IF/ID and ID/EX contents this cycle (combinational).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; all BTB valid bits=0 and counters=2'b00. Hence pred_taken=0, and flush=0 while trap_en and ex_valid are low. Reset may assert at any time and overrides everything immediately.
- BTB indexing:
  - Index = addr[IDX_W+1:2]; tag = addr[CPU_WIDTH-1:IDX_W+2]; addr[1:0] is ignored.
  - Each entry holds valid, tag, target[CPU_WIDTH-1:0] and ctr[1:0].
- Lookup (combinational on pc):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = entry target when hit, else pc+4.
- Mispredict: mispred = ex_valid & ex_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- Redirect address = ex_taken ? ex_target : ex_pc+4.
- flush = trap_en | mispred.
- Next PC, first match wins:
  1. trap_en → trap_vec.
  2. mispred → redirect address.
  3. stall → pc unchanged.
  4. pred_taken → pred_target.
  5. otherwise → pc+4.
- Trap and mispredict override stall.
- Arithmetic: all +4 additions are modulo 2^CPU_WIDTH; 32'hFFFF_FFFC+4 gives 0.
- BTB update, on the rising edge when ex_valid & ex_branch, independent of stall and trap, indexed by ex_pc:
  - Hit, ex_taken=1: ctr saturating-increment (max 2'b11); target=ex_target.
  - Hit, ex_taken=0: ctr saturating-decrement (min 2'b00); target kept.
  - Miss, ex_taken=1: allocate/overwrite with valid=1, the new tag, target=ex_target, ctr=2'b10.
  - Miss, ex_taken=0: no change.
- Alias cleanup: ex_valid & !ex_branch & hit(ex_pc) → clear that entry's valid bit.
- Same-index read/write in one cycle: lookup sees the pre-update contents; the update is visible from the next cycle.
- Latency: a prediction takes effect on the next PC in the same cycle pc is presented; a resolved mispredict redirects pc one edge after EX. Penalty is 2 flushed instructions.

Test Plan:
- Reset release: rst_n low then high, no activity → pc=0, 4, 8, 12 on successive edges; pred_taken=0; flush=0.
- Cold taken branch: ex_valid=1, ex_branch=1, ex_pc=0x10, ex_taken=1, ex_target=0x40, ex_pred_taken=0 → flush=1; next pc=0x40; entry 4 allocated with ctr=10. Later pc=0x10 → pred_taken=1, pred_target=0x40, next pc=0x40.
- Counter saturation: resolve 0x10 taken 3 times → ctr=11. Then resolve not-taken once → ctr=10, still predicts taken. Again → ctr=01, pred_taken=0 at pc=0x10.
- Wrong-target: predicted taken to 0x40, resolved taken to 0x80 → flush=1; next pc=0x80; BTB target updated to 0x80.
- Priority: trap_en=1 (trap_vec=0x100), mispred=1 and stall=1 all in one cycle → next pc=0x100; flush=1. Stall alone → pc held, flush=0.
- Alias and reset mid-operation: non-branch at ex_pc=0x50 (index 4, different tag from 0x10), with 0x50 itself not in BTB → entry untouched. Non-branch at 0x10 → entry 4 invalidated. Asserting rst_n=0 mid-stream → pc=RESET_PC immediately and all entries cleared.
